image_window_scanner: RTL and testbench
=======================================

IMAGE_WINDOW_SCANNER -- requirements
Module: image_window_scanner

Interface
REQ-001 Parameter N_C, default 5: image column count.
REQ-002 Parameter N_R, default 3: image row count.
REQ-003 Parameter K, default 2: square window side; 1 <= K <= min(N_R, N_C).
REQ-004 Parameter STRIDE, default 1: window step in rows and columns, >= 1.
REQ-005 Parameter DW, default 16: pixel width, two's complement.
REQ-006 Parameter OFFSET, default 6: signed constant added to every output pixel.
REQ-007 Parameter AW, default $clog2(N_R*N_C): pixel address width.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 wr_en  in  1  pixel write strobe.
REQ-011 wr_addr  in  AW  row-major pixel address, row*N_C+col.
REQ-012 wr_data  in  DW  pixel value.
REQ-013 start  in  1  single-cycle pulse that begins a scan.
REQ-014 busy  out  1  high from accepted start until the last window handshake completes.
REQ-015 win_valid  out  1  window data valid.
REQ-016 win_ready  in  1  consumer accepts the window.
REQ-017 win_data  out  K*K*DW  window; element (i,j) at bits [(i*K+j)*DW +: DW].
REQ-018 win_row, win_col  out  AW each  top-left coordinate of the presented window.
REQ-019 win_last  out  1  high with the final window of the scan.

Function
REQ-020 Storage shall be an N_R*N_C by DW array written on clk when wr_en=1 and busy=0; wr_en while busy=1, or with wr_addr >= N_R*N_C, shall be ignored.
REQ-021 FSM states shall be IDLE, FETCH, PRESENT; state after reset is IDLE.
REQ-022 IDLE: start=1 shall set row=col=0, busy=1, next state FETCH; start in any other state shall be ignored.
REQ-023 FETCH (one cycle): register all K*K pixels at (row+i)*N_C+(col+j), each plus OFFSET truncated to DW bits (wrap, no saturation), along with win_row/win_col/win_last; set win_valid=1; go to PRESENT.
REQ-024 Latency: first win_valid two cycles after the start pulse edge; one FETCH cycle between successive windows.
REQ-025 PRESENT: win_data, win_row, win_col and win_last shall hold stable while win_valid=1 and win_ready=0.
REQ-026 PRESENT with win_ready=1: win_valid shall drop next cycle; if win_last, go to IDLE with busy=0; else advance and go to FETCH.
REQ-027 Advance: col+=STRIDE; if col+STRIDE > N_C-K, then col=0 and row+=STRIDE; scan is raster order.
REQ-028 Window count = (floor((N_R-K)/STRIDE)+1) * (floor((N_C-K)/STRIDE)+1); win_last is high exactly on the last window.
REQ-029 win_ready while win_valid=0 shall have no effect.

Reset
REQ-030 rst=1 shall asynchronously force IDLE, busy=0, win_valid=0, win_last=0, win_data=0, win_row=0, win_col=0, and row/col counters=0.
REQ-031 Reset shall not clear pixel storage.
REQ-032 Reset mid-scan shall abort the scan; no further windows are produced until the next start.

Structure
REQ-033 The FSM state encoding shall be declared in a shared package cnn_pkg as localparams.
REQ-034 Address generation (row/col counters, stride, last detection) shall be one sub-module, window_addr_gen; gather, offset and FSM stay in the top module.

Verification
REQ-035 Defaults; load pixel[i] = -i for i=0..14; start with win_ready=1 -> first window (0,0) = {6,5,1,0} for elements (0,0),(0,1),(1,0),(1,1); 8 windows in total; last window at (1,3) = {-2,-3,-7,-8} with win_last=1.
REQ-036 STRIDE=2, same image -> exactly 2 windows, at (0,0) and (0,2); the second = {4,3,-1,-2} with win_last=1.
REQ-037 win_ready held 0 for 5 cycles on the window at (0,1) -> win_valid, win_data and win_col=1 remain stable; the window is accepted once and the next window is (0,2).
REQ-038 wr_en to addr 0 with data 100 while busy -> ignored; a rescan still gives window (0,0) element 0 = 6; the same write while idle gives 106.
REQ-039 rst asserted mid-scan between clock edges -> busy, win_valid and win_data are 0 immediately; a new start gives window (0,0) = {6,5,1,0}.
REQ-040 K=1, OFFSET=0x7FFF, pixel 1 -> output 0x8000 (wraps); 15 windows produced.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the image window scanner: FSM state encoding.
package cnn_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    FETCH   = ST_FETCH,
    PRESENT = ST_PRESENT
  } scan_state_e;

endpackage

// File: rtl/window_addr_gen.sv
// Raster-order window origin generator: row/col counters stepped by STRIDE,
// plus detection of the final window position.
module window_addr_gen #(
  parameter int N_C    = 5,
  parameter int N_R    = 3,
  parameter int K      = 2,
  parameter int STRIDE = 1,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  logic col_wrap;
  logic row_end;

  // The next column step would push the window past the right edge.
  assign col_wrap = (int'(col) + STRIDE) > (N_C - K);
  assign row_end  = (int'(row) + STRIDE) > (N_R - K);
  assign last     = col_wrap && row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + AW'(STRIDE);
      end else begin
        col <= col + AW'(STRIDE);
      end
    end
  end

endmodule

// File: rtl/image_window_scanner.sv
// Pixel store plus a K x K sliding-window scanner that presents each window
// (with a constant offset added to every pixel) over a valid/ready handshake.
module image_window_scanner
  import cnn_pkg::*;
#(
  parameter int N_C    = 5,
  parameter int N_R    = 3,
  parameter int K      = 2,
  parameter int STRIDE = 1,
  parameter int DW     = 16,
  parameter int OFFSET = 6,
  parameter int AW     = $clog2(N_R * N_C)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              start,
  output logic              busy,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output logic [AW-1:0]     win_row,
  output logic [AW-1:0]     win_col,
  output logic              win_last
);

  localparam int             NPIX      = N_R * N_C;
  localparam logic [DW-1:0]  OFFSET_DW = DW'(OFFSET);

  logic [DW-1:0] pix_mem [NPIX];

  scan_state_e state;
  scan_state_e state_nxt;

  logic              scan_clear;
  logic              scan_advance;
  logic              fetch;
  logic [AW-1:0]     cur_row;
  logic [AW-1:0]     cur_col;
  logic              cur_last;
  logic [K*K*DW-1:0] gather;

  function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] r,
                                             input logic [AW-1:0] c,
                                             input int i, input int j);
    return AW'((int'(r) + i) * N_C + int'(c) + j);
  endfunction

  assign busy      = (state != IDLE);
  assign win_valid = (state == PRESENT);

  // Pixel storage is frozen during a scan and deliberately survives reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (int'(wr_addr) < NPIX)) begin
      pix_mem[wr_addr] <= wr_data;
    end
  end

  window_addr_gen #(
    .N_C    (N_C),
    .N_R    (N_R),
    .K      (K),
    .STRIDE (STRIDE),
    .AW     (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (scan_clear),
    .advance (scan_advance),
    .row     (cur_row),
    .col     (cur_col),
    .last    (cur_last)
  );

  // Offset addition wraps at DW bits; no saturation.
  always_comb begin
    gather = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        gather[(i*K+j)*DW +: DW] = pix_mem[pix_addr(cur_row, cur_col, i, j)] + OFFSET_DW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    scan_clear   = 1'b0;
    scan_advance = 1'b0;
    fetch        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          scan_clear = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        fetch     = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (win_ready) begin
          if (win_last) begin
            state_nxt = IDLE;
          end else begin
            scan_advance = 1'b1;
            state_nxt    = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window registers only load in FETCH, so they hold through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_data <= '0;
      win_row  <= '0;
      win_col  <= '0;
      win_last <= 1'b0;
    end else if (fetch) begin
      win_data <= gather;
      win_row  <= cur_row;
      win_col  <= cur_col;
      win_last <= cur_last;
    end
  end

endmodule

// File: tb/tb_image_window_scanner.sv
// Self-checking bench: three scanner configurations driven in parallel and
// compared every cycle against a window-list model of the image.
module tb_image_window_scanner;

  localparam int NC   = 5;
  localparam int NR   = 3;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NPIX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          win_ready = 1'b0;

  logic          busy_a, valid_a, last_a, busy_b, valid_b, last_b, busy_c, valid_c, last_c;
  logic [63:0]   data_a, data_b;
  logic [15:0]   data_c;
  logic [AW-1:0] row_a, col_a, row_b, col_b, row_c, col_c;

  logic          dut_busy  [3];
  logic          dut_valid [3];
  logic          dut_last  [3];
  logic [63:0]   dut_data  [3];
  logic [AW-1:0] dut_row   [3];
  logic [AW-1:0] dut_col   [3];

  logic [15:0] img [3][NPIX];
  bit          mbusy [3];
  int          widx [3];
  int          ready_at [3];
  int          cyc = 0;
  int          seen_acc [3];
  logic [63:0] captured [3][16];
  logic [7:0]  cap_pos [3][16];

  int vectors = 0;
  int miscompares = 0;

  image_window_scanner #(.N_C(NC), .N_R(NR), .K(2), .STRIDE(1), .DW(DW), .OFFSET(6), .AW(AW)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .busy(busy_a), .win_valid(valid_a), .win_ready(win_ready), .win_data(data_a),
    .win_row(row_a), .win_col(col_a), .win_last(last_a));

  image_window_scanner #(.N_C(NC), .N_R(NR), .K(2), .STRIDE(2), .DW(DW), .OFFSET(6), .AW(AW)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .busy(busy_b), .win_valid(valid_b), .win_ready(win_ready), .win_data(data_b),
    .win_row(row_b), .win_col(col_b), .win_last(last_b));

  image_window_scanner #(.N_C(NC), .N_R(NR), .K(1), .STRIDE(1), .DW(DW), .OFFSET(32'h7FFF), .AW(AW)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .busy(busy_c), .win_valid(valid_c), .win_ready(win_ready), .win_data(data_c),
    .win_row(row_c), .win_col(col_c), .win_last(last_c));

  always #5 clk = ~clk;

  always_comb begin
    dut_busy[0] = busy_a;  dut_valid[0] = valid_a; dut_last[0] = last_a;
    dut_data[0] = data_a;  dut_row[0] = row_a;     dut_col[0] = col_a;
    dut_busy[1] = busy_b;  dut_valid[1] = valid_b; dut_last[1] = last_b;
    dut_data[1] = data_b;  dut_row[1] = row_b;     dut_col[1] = col_b;
    dut_busy[2] = busy_c;  dut_valid[2] = valid_c; dut_last[2] = last_c;
    dut_data[2] = {48'd0, data_c}; dut_row[2] = row_c; dut_col[2] = col_c;
  end

  function automatic int cfg_k(input int m);
    return (m == 2) ? 1 : 2;
  endfunction

  function automatic int cfg_s(input int m);
    return (m == 1) ? 2 : 1;
  endfunction

  function automatic int cfg_off(input int m);
    return (m == 2) ? 32'h7FFF : 6;
  endfunction

  function automatic int n_cols(input int m);
    return (NC - cfg_k(m)) / cfg_s(m) + 1;
  endfunction

  function automatic int n_wins(input int m);
    return ((NR - cfg_k(m)) / cfg_s(m) + 1) * n_cols(m);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input bit st, input bit rdy);
    @(posedge clk);
    #1;
    wr_en     = we;
    wr_addr   = a;
    wr_data   = d;
    start     = st;
    win_ready = rdy;
  endtask

  task automatic wait_valid(input int m, input int col, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = dut_valid[m] && (col < 0 || int'(dut_col[m]) == col);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout_valid[%0d]: no window seen, required col %0d", m, col);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = !dut_busy[0] && !dut_busy[1] && !dut_busy[2];
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout_idle: busy still %0b%0b%0b, required 000",
               dut_busy[0], dut_busy[1], dut_busy[2]);
    end
  endtask

  task automatic clear_seen();
    for (int m = 0; m < 3; m++) seen_acc[m] = 0;
  endtask

  // Reference model: which window each instance should be presenting, and when.
  initial begin : model_proc
    bit old_busy;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int m = 0; m < 3; m++) mbusy[m] = 1'b0;
      end else begin
        for (int m = 0; m < 3; m++) begin
          old_busy = mbusy[m];
          if (mbusy[m]) begin
            if (cyc >= ready_at[m] && win_ready) begin
              widx[m] = widx[m] + 1;
              if (widx[m] == n_wins(m)) mbusy[m] = 1'b0;
              else ready_at[m] = cyc + 2;
            end
          end else if (start) begin
            mbusy[m]    = 1'b1;
            widx[m]     = 0;
            ready_at[m] = cyc + 2;
          end
          if (wr_en && !old_busy && int'(wr_addr) < NPIX) img[m][wr_addr] = wr_data;
        end
        cyc++;
      end
    end
  end

  initial begin : compare_proc
    int r, c, k, nc;
    bit mv;
    logic [15:0] expv;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int m = 0; m < 3; m++) begin
          mv = mbusy[m] && (cyc >= ready_at[m]);
          checkOutput($sformatf("busy[%0d]", m), 64'(dut_busy[m]), 64'(mbusy[m]));
          checkOutput($sformatf("valid[%0d]", m), 64'(dut_valid[m]), 64'(mv));
          if (mv && dut_valid[m]) begin
            k  = cfg_k(m);
            nc = n_cols(m);
            r  = (widx[m] / nc) * cfg_s(m);
            c  = (widx[m] % nc) * cfg_s(m);
            checkOutput($sformatf("row[%0d]", m), 64'(dut_row[m]), 64'(r));
            checkOutput($sformatf("col[%0d]", m), 64'(dut_col[m]), 64'(c));
            checkOutput($sformatf("last[%0d]", m), 64'(dut_last[m]), 64'(widx[m] == n_wins(m) - 1));
            for (int i = 0; i < k; i++) begin
              for (int j = 0; j < k; j++) begin
                expv = 16'(int'(img[m][(r + i) * NC + c + j]) + cfg_off(m));
                checkOutput($sformatf("data[%0d](%0d,%0d)", m, i, j),
                            64'(dut_data[m][(i*k+j)*16 +: 16]), 64'(expv));
              end
            end
          end
          if (dut_valid[m] && win_ready) begin
            captured[m][seen_acc[m] % 16] = dut_data[m];
            cap_pos[m][seen_acc[m] % 16]  = {dut_row[m], dut_col[m]};
            seen_acc[m]++;
          end
        end
      end
    end
  end

  initial begin : stimulus_proc
    logic [63:0] snap;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      checkOutput($sformatf("rst_busy[%0d]", m), 64'(dut_busy[m]), 64'd0);
      checkOutput($sformatf("rst_valid[%0d]", m), 64'(dut_valid[m]), 64'd0);
      checkOutput($sformatf("rst_data[%0d]", m), dut_data[m], 64'd0);
      checkOutput($sformatf("rst_pos[%0d]", m), 64'({dut_row[m], dut_col[m]}), 64'd0);
      checkOutput($sformatf("rst_last[%0d]", m), 64'(dut_last[m]), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, AW'(i), 16'(-i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Full scan, consumer always ready.
    clear_seen();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(100);
    checkOutput("a_first", captured[0][0], 64'h0000_0001_0005_0006);
    checkOutput("a_count", 64'(seen_acc[0]), 64'd8);
    checkOutput("a_last_data", captured[0][7], 64'hFFF8_FFF9_FFFD_FFFE);
    checkOutput("a_last_pos", 64'(cap_pos[0][7]), 64'h13);
    checkOutput("b_count", 64'(seen_acc[1]), 64'd2);
    checkOutput("b_second_data", captured[1][1], 64'hFFFE_FFFF_0003_0004);
    checkOutput("b_second_pos", 64'(cap_pos[1][1]), 64'h02);
    checkOutput("c_count", 64'(seen_acc[2]), 64'd15);
    checkOutput("c_first", captured[2][0], 64'h7FFF);

    // Stall on the window at (0,1).
    clear_seen();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid(0, 0, 20);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid(0, 1, 20);
    snap = data_a;
    repeat (5) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("stall_valid", 64'(valid_a), 64'd1);
    checkOutput("stall_data", data_a, snap);
    checkOutput("stall_col", 64'(col_a), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(100);
    checkOutput("stall_count", 64'(seen_acc[0]), 64'd8);
    checkOutput("stall_pos1", 64'(cap_pos[0][1]), 64'h01);
    checkOutput("stall_pos2", 64'(cap_pos[0][2]), 64'h02);

    // Write while busy is dropped; the same write while idle lands.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid(0, 0, 20);
    applyStimulus(1'b1, 4'd0, 16'd100, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(100);
    clear_seen();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(100);
    checkOutput("busy_write_ignored", 64'(captured[0][0][15:0]), 64'd6);
    applyStimulus(1'b1, 4'd0, 16'd100, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd1, 16'd1, 1'b0, 1'b1);
    clear_seen();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(100);
    checkOutput("idle_write_taken", 64'(captured[0][0][15:0]), 64'd106);
    checkOutput("c_wrap_100", captured[2][0], 64'h8063);
    checkOutput("c_wrap_1", captured[2][1], 64'h8000);

    // Asynchronous reset in the middle of a scan.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    wait_valid(0, -1, 20);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy_a), 64'd0);
    checkOutput("midrst_valid", 64'(valid_a), 64'd0);
    checkOutput("midrst_data", data_a, 64'd0);
    checkOutput("midrst_busy_c", 64'(busy_c), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 4'd0, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd1, 16'hFFFF, 1'b0, 1'b0);
    clear_seen();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(100);
    checkOutput("post_rst_first", captured[0][0], 64'h0000_0001_0005_0006);
    checkOutput("post_rst_count", 64'(seen_acc[0]), 64'd8);

    // Random traffic: writes (some out of range), stray starts, random ready.
    repeat (800) begin
      applyStimulus($urandom_range(0, 5) == 0, AW'($urandom_range(0, 15)), 16'($urandom),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
